// File: rtl/core_ctrl_axi_if.sv
// AXI4 bus bundle between the control interconnect and the core control slave.
interface core_ctrl_axi_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 19,
  parameter int ID_WIDTH   = 8
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/core_ctrl_axi_slave.sv
// Terminates host control writes/reads to the per-core control word and
// drives per-core reset and 32-bit config outputs.
//
// state  | meaning
// W_IDLE | awready=1, waiting for a write address
// W_DATA | wready=1, accepting beats until wlast
// W_RESP | bvalid=1, waiting for bready
// R_IDLE | arready=1, waiting for a read address
// R_DATA | rvalid=1, returning len+1 beats
module core_ctrl_axi_slave #(
  parameter int              DATA_WIDTH  = 64,
  parameter int              ADDR_WIDTH  = 19,
  parameter int              ID_WIDTH    = 8,
  parameter int              RISCV_CORES = 8,
  parameter logic [15:0]     CTRL_OFFSET = 16'hFFF8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  core_ctrl_axi_if.slave             s_axi,
  output logic [RISCV_CORES-1:0]     o_core_reset,
  output logic [RISCV_CORES*32-1:0]  o_core_cfg
);
  localparam int STRB_WIDTH    = DATA_WIDTH / 8;
  localparam int CORE_NO_WIDTH = $clog2(RISCV_CORES);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  wstate_t r_wstate, w_wstate_nxt;
  rstate_t r_rstate, w_rstate_nxt;

  logic [ID_WIDTH-1:0]      r_aw_id;
  logic [CORE_NO_WIDTH-1:0] r_aw_core;
  logic                     r_aw_hit;
  logic [ID_WIDTH-1:0]      r_ar_id;
  logic [7:0]               r_ar_cnt;
  logic                     r_ar_hit;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic [RISCV_CORES-1:0]   r_core_reset;
  logic [31:0]              r_core_cfg [RISCV_CORES];

  logic                     w_aw_fire, w_w_last, w_w_commit, w_ar_fire, w_r_fire;
  logic                     w_aw_hit, w_ar_hit;
  logic [CORE_NO_WIDTH-1:0] w_ar_core;
  logic                     w_unused;

  // Size/burst/lock/cache/prot and the reserved data/strobe bits have no effect.
  assign w_unused = &{s_axi.awsize, s_axi.awburst, s_axi.awlock, s_axi.awcache, s_axi.awprot,
                      s_axi.arsize, s_axi.arburst, s_axi.arlock, s_axi.arcache, s_axi.arprot,
                      s_axi.wstrb[STRB_WIDTH-2:4], s_axi.wdata[DATA_WIDTH-1:57],
                      s_axi.wdata[55:32]};

  assign w_aw_hit   = (s_axi.awaddr[15:0] == CTRL_OFFSET) && (s_axi.awlen == 8'd0);
  assign w_ar_hit   = (s_axi.araddr[15:0] == CTRL_OFFSET) && (s_axi.arlen == 8'd0);
  assign w_ar_core  = s_axi.araddr[ADDR_WIDTH-1:16];
  assign w_aw_fire  = (r_wstate == W_IDLE) && s_axi.awvalid;
  assign w_w_last   = (r_wstate == W_DATA) && s_axi.wvalid && s_axi.wlast;
  assign w_w_commit = w_w_last && r_aw_hit;
  assign w_ar_fire  = (r_rstate == R_IDLE) && s_axi.arvalid;
  assign w_r_fire   = (r_rstate == R_DATA) && s_axi.rready;

  // Write FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_wstate <= W_IDLE;
    else       r_wstate <= w_wstate_nxt;
  end

  // Write FSM next state.
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (s_axi.awvalid) w_wstate_nxt = W_DATA;
      W_DATA:  if (w_w_last)      w_wstate_nxt = W_RESP;
      W_RESP:  if (s_axi.bready)  w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write channel handshake outputs decoded from state.
  always_comb begin
    s_axi.awready = (r_wstate == W_IDLE);
    s_axi.wready  = (r_wstate == W_DATA);
    s_axi.bvalid  = (r_wstate == W_RESP);
    s_axi.bresp   = ((r_wstate == W_RESP) && !r_aw_hit) ? 2'b10 : 2'b00;
    s_axi.bid     = r_aw_id;
  end

  // Latch the write address phase.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_aw_id   <= '0;
      r_aw_core <= '0;
      r_aw_hit  <= 1'b0;
    end else if (w_aw_fire) begin
      r_aw_id   <= s_axi.awid;
      r_aw_core <= s_axi.awaddr[ADDR_WIDTH-1:16];
      r_aw_hit  <= w_aw_hit;
    end
  end

  // Control registers, updated only when a hit write completes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_core_reset <= '1;
      for (int c = 0; c < RISCV_CORES; c++) r_core_cfg[c] <= '0;
    end else if (w_w_commit) begin
      for (int b = 0; b < 4; b++)
        if (s_axi.wstrb[b]) r_core_cfg[r_aw_core][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
      if (s_axi.wstrb[7]) r_core_reset[r_aw_core] <= s_axi.wdata[56];
    end
  end

  // Flatten per-core config onto the output bus.
  always_comb begin
    o_core_reset = r_core_reset;
    o_core_cfg   = '0;
    for (int c = 0; c < RISCV_CORES; c++) o_core_cfg[c*32 +: 32] = r_core_cfg[c];
  end

  // Read FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_rstate <= R_IDLE;
    else       r_rstate <= w_rstate_nxt;
  end

  // Read FSM next state.
  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (s_axi.arvalid) w_rstate_nxt = R_DATA;
      R_DATA:  if (s_axi.rready && (r_ar_cnt == 8'd0)) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read channel outputs decoded from state.
  always_comb begin
    s_axi.arready = (r_rstate == R_IDLE);
    s_axi.rvalid  = (r_rstate == R_DATA);
    s_axi.rlast   = (r_rstate == R_DATA) && (r_ar_cnt == 8'd0);
    s_axi.rresp   = ((r_rstate == R_DATA) && !r_ar_hit) ? 2'b10 : 2'b00;
    s_axi.rdata   = r_rdata;
    s_axi.rid     = r_ar_id;
  end

  // Snapshot the word at AR time so a same-cycle write shows the old value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ar_id  <= '0;
      r_ar_cnt <= '0;
      r_ar_hit <= 1'b0;
      r_rdata  <= '0;
    end else if (w_ar_fire) begin
      r_ar_id  <= s_axi.arid;
      r_ar_cnt <= s_axi.arlen;
      r_ar_hit <= w_ar_hit;
      r_rdata  <= '0;
      if (w_ar_hit) begin
        r_rdata[31:0] <= r_core_cfg[w_ar_core];
        r_rdata[56]   <= r_core_reset[w_ar_core];
      end
    end else if (w_r_fire && (r_ar_cnt != 8'd0)) begin
      r_ar_cnt <= r_ar_cnt - 8'd1;
    end
  end
endmodule
